// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for the instruction memory
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [0:7]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [0:ADDR_W-1] imem_addr,
  output logic [0:31]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  // Word index is one bit wider than the count so index == count never wraps.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] word_len;
  logic [16:0] word_idx;
  logic [16:0] idx_next;
  logic [1:0]  byte_idx;
  logic [0:31] word_reg;
  logic        loaded;
  logic        xfer;
  logic        in_range;
  logic        last_word;

  assign xfer      = byte_valid & byte_ready;
  assign in_range  = word_idx < CAPACITY;
  assign idx_next  = word_idx + 17'd1;
  assign last_word = idx_next == {1'b0, word_len};

  assign imem_addr  = word_idx[ADDR_W-1:0];
  assign imem_wdata = word_reg;
  // Core runs only while idle after a load that completed since reset.
  assign core_hold  = !((state == S_IDLE) && loaded);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = ({word_len[15:8], byte_in} == 16'd0) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (xfer && (byte_idx == 2'd3)) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        imem_we   = in_range;
        state_nxt = last_word ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, indices and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_len <= 16'd0;
      word_idx <= 17'd0;
      byte_idx <= 2'd0;
      word_reg <= 32'd0;
      loaded   <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err      <= 1'b0;
            word_idx <= 17'd0;
            byte_idx <= 2'd0;
          end
        end
        S_LEN_HI: begin
          if (xfer) word_len[15:8] <= byte_in;
        end
        S_LEN_LO: begin
          if (xfer) word_len[7:0] <= byte_in;
        end
        S_DATA: begin
          if (xfer) begin
            // First byte ends up in wdata[0:7] after four shifts.
            word_reg <= {word_reg[8:31], byte_in};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          // Words past capacity are consumed but flagged, never written.
          if (!in_range) err <= 1'b1;
          word_idx <= idx_next;
        end
        S_DONE: begin
          loaded <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory of the single-cycle core from a byte-wide host stream while holding the core stalled. It sits between an external host link (UART/JTAG bridge) and the write port of the instruction memory. It assembles big-endian 32-bit instruction words, writes them at consecutive word addresses starting at 0, and releases the core when the load completes. It is the writer counterpart of the core's instruction-fetch read path.

## Interface
Parameters:
- ADDR_W, 8, word-address width of instruction memory; capacity 2**ADDR_W words

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to begin a load; honoured only in IDLE
- byte_in  in  [0:7]  host data byte, bit 0 = MSB
- byte_valid  in  1  host has a byte on byte_in
- byte_ready  out  1  loader accepts byte_in this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  [0:ADDR_W-1]  word address for the write
- imem_wdata  out  [0:31]  instruction word, bit 0 = MSB
- core_hold  out  1  stall/reset request to the core (PC held)
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when the load finishes
- err  out  1  sticky: the last load declared more words than capacity

## Operation
- Stream format: 2-byte word count N (high byte first), then 4*N data bytes, each word big-endian (first byte -> wdata[0:7], fourth -> wdata[24:31]).
- Byte transfer occurs on a rising edge with byte_valid & byte_ready both high; otherwise byte_in is ignored.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE.
- IDLE: byte_ready=0; start -> LEN_HI, clear err, word index and byte index to 0.
- LEN_HI: byte_ready=1; on transfer latch N[15:8] -> LEN_LO.
- LEN_LO: byte_ready=1; on transfer latch N[7:0]; if N==0 -> DONE, else -> DATA.
- DATA: byte_ready=1; on each transfer shift the byte into the word register, byte index +1; on the 4th byte -> WRITE.
- WRITE: byte_ready=0; imem_we=1 only if word index < 2**ADDR_W, imem_addr = word index[ADDR_W-1:0]; otherwise set err and suppress the write (data is consumed and discarded). Word index +1; if it now equals N -> DONE, else -> DATA.
- DONE: done=1 for exactly one cycle -> IDLE.
- N is 16-bit unsigned; the word index is 17 bits wide so comparison with N never wraps.
- core_hold: 1 from reset until the first DONE; 1 from start acceptance through DONE; 0 in IDLE after a completed load.
- busy = 1 in LEN_HI, LEN_LO, DATA, WRITE, DONE.
- start while not in IDLE: ignored.

## Timing
- Reset values (rst=0 at an edge): state IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, busy=0, done=0, err=0.
- Reset mid-load: same values; the partial word is discarded, and memory writes already performed remain.
- Start accepted at edge k: byte_ready=1 from cycle k+1.
- With continuous byte_valid, each word takes 5 cycles: 4 transfers plus 1 WRITE cycle. imem_we rises in the cycle after the 4th byte edge.
- Last word: WRITE -> DONE -> IDLE. done and core_hold fall together at the edge leaving DONE.
- N==0: DONE is entered the cycle after the LEN_LO transfer, with no imem_we.
- imem_addr and imem_wdata are stable and valid whenever imem_we=1. The bench must not sample them at other times.
- Host stalls (byte_valid=0) only delay the FSM; no timeout.

## Test plan
- Reset: hold rst=0 for 3 cycles -> core_hold=1, every other output 0, state IDLE.
- Two-word load: start, then bytes 00 02 20 01 00 05 00 22 18 20 -> imem_we pulses at addr 0 with 0x20010005 and at addr 1 with 0x00221820, then one done pulse, core_hold falls, err=0.
- Zero-length load: start, then 00 00 -> done one cycle after the second byte, no imem_we, core_hold falls.
- Stalled host: same two-word stream with byte_valid randomly low (≥30% of cycles) -> identical writes and done. byte_ready is 0 in every WRITE cycle and no byte is lost or duplicated.
- Overflow (ADDR_W=8): N=0x0101, 1028 data bytes -> exactly 256 writes at addr 0..255, the 257th word is consumed without a write, err=1 at done.
- Reset mid-DATA: rst=0 after 2 bytes of word 0 -> reset values restored, then a fresh two-word load completes correctly.
